tcp_rx_ack_scheduler: RTL
=========================

// Module: tcp_rx_ack_scheduler
// PURPOSE
//  Decides when the TCP receive side emits a pure ACK / window-update segment.
//  Watches the in-order delivery progress of the RX reassembly store (ack number, free window).
//  Issues one ACK request at a time to the TX header builder over a valid/ready handshake.
//  Sits between the RX store and the TX segment generator; one instance per connection.
// PARAMETERS
//  ACK_BYTE_THRESH    2920   newly delivered bytes (2*MSS) that force an immediate ACK
//  DELAY_CYCLES       31250  delayed-ACK timeout in aclk cycles (200 us @ 156.25 MHz)
//  WIN_UPDATE_THRESH  2920   window growth since last advertisement that forces a window update
//  TIMER_WIDTH        16     delayed-ACK counter width; must hold DELAY_CYCLES
// PORTS
//  aclk                 in   1   clock
//  aresetn              in   1   asynchronous active-low reset
//  established          in   1   level: connection in ESTABLISHED
//  rx_store_signal      in   1   pulse: rx_store_ack_number advanced this cycle
//  rx_store_ack_number  in   32  next expected seq, numeric (host) order
//  rx_window_size       in   16  current free receive window, bytes
//  force_ack            in   1   pulse: out-of-order/duplicate segment, ACK now
//  ack_req_valid        out  1   ACK request pending to TX builder
//  ack_req_ready        in   1   TX builder accepts request
//  ack_req_number       out  32  ack number to send, numeric order
//  ack_req_window       out  16  window to advertise
//  ack_req_reason       out  2   0 bytes, 1 timer, 2 window, 3 force
//  ack_pending          out  1   unacknowledged delivered data exists
// BEHAVIOUR
//  Reset: all outputs 0; last_acked, last_win, cur_ack, timer = 0; state IDLE.
//  Registers: cur_ack (latest rx_store_ack_number on rx_store_signal), last_acked, last_win.
//  Rising edge of established: last_acked := cur_ack := rx_store_ack_number, last_win := rx_window_size; no ACK.
//  delta = cur_ack - last_acked, 32-bit modular; delta[31]=1 treated as 0 (stale, wrap-safe).
//  win_gain = rx_window_size - last_win when rx_window_size > last_win, else 0.
//  Triggers, priority force > bytes > window > timer:
//   force  : force_ack pulse seen (latched until served)
//   bytes  : delta >= ACK_BYTE_THRESH
//   window : win_gain >= WIN_UPDATE_THRESH
//   timer  : delta != 0 and timer == DELAY_CYCLES-1
//  FSM:
//   IDLE    -> PENDING on delta!=0; -> REQ on any trigger
//   PENDING : timer increments each cycle (saturates); -> REQ on any trigger
//   REQ     : ack_req_valid=1; payload snapshotted on entry (cur_ack, rx_window_size, reason)
//            and held stable until ack_req_ready; on handshake: last_acked := snapshot number,
//            last_win := snapshot window, timer := 0, force latch cleared unless re-pulsed in that cycle;
//            next state REQ if a trigger holds vs new last_*, PENDING if delta!=0, else IDLE.
//  Latency: trigger true in cycle N -> ack_req_valid high in cycle N+1. Back-to-back requests allowed
//   (valid may stay high across handshake with a new payload the following cycle).
//  Updates arriving during REQ accumulate in cur_ack; they never alter the held payload.
//  ack_pending = (delta != 0) combinational from registers.
//  timer resets to 0 on handshake and when entering IDLE; starts counting on IDLE->PENDING.
//  established low: next cycle state IDLE, ack_req_valid 0 (permitted abort), latches cleared.
//  rx_store_signal and handshake in the same cycle: handshake uses snapshot, cur_ack takes new value.
//  aresetn asserted mid-request: immediate return to reset values; no partial request replayed.
// STRUCTURE
//  Shared TCP package: ack reason encoding (ACK_RSN_BYTES/TIMER/WINDOW/FORCE), MSS constant,
//   modular seq-difference function (seq_diff) reused by TX retransmit logic.
//  One sub-module natural: tcp_delack_timer (saturating counter, clear/enable/expired).
//  Remainder is a single FSM + datapath registers.
// TESTING
//  Establish with ack=0x1000, win=16383; deliver 1460 B -> no ACK until 31250 cycles, then ACK num 0x15B4, reason 1.
//  Deliver 2*1460 B back-to-back -> ACK next cycle, num 0x1B68, reason 0, timer cleared.
//  ack from 0xFFFFFA00 to 0x00000574 (+2932 across wrap) -> reason 0 ACK num 0x00000574; stale lower seq -> no ACK.
//  Window 8000 -> 11000 with no data -> window update, reason 2, num unchanged; ready held low 10 cycles -> payload stable.
//  force_ack with bytes trigger same cycle -> reason 3; further delivery during REQ -> second ACK after handshake.
//  established dropped while valid=1 / aresetn mid-REQ -> valid low next cycle / immediately, state IDLE.

Source files
------------

// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared TCP types, constants and sequence-number helpers
//
// Purpose: common definitions for the TCP offload blocks (ACK scheduler,
//          TX retransmit logic).
// Ports:   none (package).

package tcp_pkg;

    localparam int unsigned TCP_MSS = 1460;

    // Reason code carried with every pure ACK / window-update request.
    typedef enum logic [1:0] {
        ACK_RSN_BYTES  = 2'd0,
        ACK_RSN_TIMER  = 2'd1,
        ACK_RSN_WINDOW = 2'd2,
        ACK_RSN_FORCE  = 2'd3
    } ack_reason_e;

    typedef enum logic [1:0] {
        ACK_ST_IDLE    = 2'd0,
        ACK_ST_PENDING = 2'd1,
        ACK_ST_REQ     = 2'd2
    } ack_state_e;

    // Modular distance a - b in sequence space; bit 31 set means b is ahead of a.
    function automatic logic [31:0] seq_diff(input logic [31:0] a, input logic [31:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/tcp_delack_timer.sv
// rtl/tcp_delack_timer.sv - saturating delayed-ACK timer
//
// Purpose: counts enabled cycles from 0 up to LIMIT-1 and holds there.
// Ports:   clk_i, rst_ni (async active-low)
//          clear_i   - return count to 0 (wins over enable_i)
//          enable_i  - advance count by one this cycle
//          expired_o - count has reached LIMIT-1

module tcp_delack_timer #(
    parameter int          WIDTH = 16,
    parameter int unsigned LIMIT = 31250
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/tcp_rx_ack_scheduler.sv
// rtl/tcp_rx_ack_scheduler.sv - decides when the RX side emits a pure ACK / window update
//
// Purpose: tracks in-order delivery (ack number) and free window, and raises one
//          ACK request at a time toward the TX header builder.
// Ports:   aclk, aresetn (async active-low)
//          established                  - connection is in ESTABLISHED
//          rx_store_signal / _ack_number - delivery progress from the reassembly store
//          rx_window_size               - current free receive window
//          force_ack                    - out-of-order/duplicate seen, ACK now
//          ack_req_valid/_ready         - request handshake to TX builder
//          ack_req_number/_window/_reason - request payload, stable while valid
//          ack_pending                  - delivered data not yet acknowledged

module tcp_rx_ack_scheduler
    import tcp_pkg::*;
#(
    parameter int unsigned ACK_BYTE_THRESH   = 2 * TCP_MSS,
    parameter int unsigned DELAY_CYCLES      = 31250,
    parameter int unsigned WIN_UPDATE_THRESH = 2 * TCP_MSS,
    parameter int          TIMER_WIDTH       = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        established,
    input  logic        rx_store_signal,
    input  logic [31:0] rx_store_ack_number,
    input  logic [15:0] rx_window_size,
    input  logic        force_ack,
    output logic        ack_req_valid,
    input  logic        ack_req_ready,
    output logic [31:0] ack_req_number,
    output logic [15:0] ack_req_window,
    output logic [1:0]  ack_req_reason,
    output logic        ack_pending
);

    localparam logic [31:0] BYTE_TH = 32'(ACK_BYTE_THRESH);
    localparam logic [15:0] WIN_TH  = 16'(WIN_UPDATE_THRESH);

    ack_state_e  state_q;
    logic        est_q;
    logic        force_q;
    logic [31:0] cur_ack_q;
    logic [31:0] last_acked_q;
    logic [15:0] last_win_q;

    logic        timer_expired;
    logic        hs;
    logic [31:0] delta;
    logic [31:0] post_delta;
    logic [15:0] gain;
    logic [15:0] post_gain;
    logic [2:0]  live_trig;
    logic [2:0]  post_trig;

    // A backwards ack number is a stale report, never "4 GB of new data".
    function automatic logic [31:0] clamp_delta(input logic [31:0] d);
        return d[31] ? 32'd0 : d;
    endfunction

    // Returns {fire, reason} with priority force > bytes > window > timer.
    function automatic logic [2:0] eval_trig(input logic f, input logic [31:0] d,
                                             input logic [15:0] g, input logic t);
        if (f)                    return {1'b1, ACK_RSN_FORCE};
        else if (d >= BYTE_TH)    return {1'b1, ACK_RSN_BYTES};
        else if (g >= WIN_TH)     return {1'b1, ACK_RSN_WINDOW};
        else if (t && (d != '0))  return {1'b1, ACK_RSN_TIMER};
        else                      return 3'b000;
    endfunction

    assign hs         = ack_req_valid && ack_req_ready;
    assign delta      = clamp_delta(seq_diff(cur_ack_q, last_acked_q));
    assign gain       = (rx_window_size > last_win_q) ? (rx_window_size - last_win_q) : 16'd0;
    // Evaluated against the payload being handed over, which becomes the new last_*.
    assign post_delta = clamp_delta(seq_diff(cur_ack_q, ack_req_number));
    assign post_gain  = (rx_window_size > ack_req_window) ? (rx_window_size - ack_req_window) : 16'd0;

    // The raw force pulse is included so a force trigger still meets one-cycle latency.
    assign live_trig  = eval_trig(force_q | force_ack, delta, gain, timer_expired);
    // Timer restarts at 0 on handshake, so it can never fire here.
    assign post_trig  = eval_trig(force_ack, post_delta, post_gain, 1'b0);

    assign ack_pending = (delta != '0);

    tcp_delack_timer #(
        .WIDTH (TIMER_WIDTH),
        .LIMIT (DELAY_CYCLES)
    ) u_delack_timer (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .clear_i   (state_q != ACK_ST_PENDING),
        .enable_i  (state_q == ACK_ST_PENDING),
        .expired_o (timer_expired)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= ACK_ST_IDLE;
            est_q          <= 1'b0;
            force_q        <= 1'b0;
            cur_ack_q      <= '0;
            last_acked_q   <= '0;
            last_win_q     <= '0;
            ack_req_valid  <= 1'b0;
            ack_req_number <= '0;
            ack_req_window <= '0;
            ack_req_reason <= '0;
        end else begin
            est_q <= established;
            if (!established) begin
                // Abort: any outstanding request is withdrawn.
                state_q       <= ACK_ST_IDLE;
                ack_req_valid <= 1'b0;
                force_q       <= 1'b0;
            end else if (!est_q) begin
                // Fresh connection: the peer already knows this ack/window, nothing to send.
                cur_ack_q     <= rx_store_ack_number;
                last_acked_q  <= rx_store_ack_number;
                last_win_q    <= rx_window_size;
                force_q       <= 1'b0;
                state_q       <= ACK_ST_IDLE;
                ack_req_valid <= 1'b0;
            end else begin
                if (rx_store_signal) begin
                    cur_ack_q <= rx_store_ack_number;
                end
                if (force_ack) begin
                    force_q <= 1'b1;
                end
                case (state_q)
                    ACK_ST_IDLE, ACK_ST_PENDING: begin
                        if (live_trig[2]) begin
                            state_q        <= ACK_ST_REQ;
                            ack_req_valid  <= 1'b1;
                            ack_req_number <= cur_ack_q;
                            ack_req_window <= rx_window_size;
                            ack_req_reason <= live_trig[1:0];
                        end else begin
                            state_q <= (delta != '0) ? ACK_ST_PENDING : ACK_ST_IDLE;
                        end
                    end
                    ACK_ST_REQ: begin
                        if (hs) begin
                            last_acked_q <= ack_req_number;
                            last_win_q   <= ack_req_window;
                            force_q      <= force_ack;
                            if (post_trig[2]) begin
                                ack_req_number <= cur_ack_q;
                                ack_req_window <= rx_window_size;
                                ack_req_reason <= post_trig[1:0];
                            end else begin
                                ack_req_valid <= 1'b0;
                                state_q <= (post_delta != '0) ? ACK_ST_PENDING : ACK_ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q       <= ACK_ST_IDLE;
                        ack_req_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
